// File: rtl/pfb_sequencer_if.sv
// Handshake bundle between the PFB sequencer, its sample source and the PE-chain datapath.
interface pfb_sequencer_if #(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 32
);
    localparam int PW = $clog2(FFT_LEN);

    logic                    run;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    ds_ready;
    logic                    dp_en;
    logic                    dp_vin;
    logic signed [WIDTH-1:0] dp_din;
    logic                    frame_start;
    logic [PW-1:0]           phase_idx;
    logic                    primed;
    logic                    busy;

    modport master (
        output run, s_data, s_valid, ds_ready,
        input  s_ready, dp_en, dp_vin, dp_din, frame_start, phase_idx, primed, busy
    );

    modport slave (
        input  run, s_data, s_valid, ds_ready,
        output s_ready, dp_en, dp_vin, dp_din, frame_start, phase_idx, primed, busy
    );
endinterface

// File: rtl/pfb_sequencer.sv
// Frame sequencer for the oversampled polyphase filter: D load steps then M-D loopback steps
// per frame, stalled by input starvation (load only) and downstream back-pressure.
module pfb_sequencer #(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 32,
    parameter int DEC_FAC = 24,
    parameter int PTAPS   = 8
) (
    input  logic            clk,
    input  logic            rst,
    pfb_sequencer_if.slave  bus
);
    localparam int CW = $clog2(FFT_LEN);
    localparam int FW = $clog2(PTAPS + 1);

    localparam logic [CW-1:0] CYC_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CYC_ONE    = CW'(1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(DEC_FAC - 1);
    localparam logic [CW-1:0] LOOP_FIRST = CW'(DEC_FAC);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FFT_LEN - 1);
    localparam logic [CW-1:0] PHASE_INC  = CW'(DEC_FAC);
    localparam logic [FW-1:0] FRAMES_FULL = FW'(PTAPS);
    localparam logic [FW-1:0] FRAMES_ONE  = FW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LOOP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cyc_ctr;
    logic [CW-1:0] w_cyc_nxt;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] w_phase_nxt;
    logic [FW-1:0] r_frame_cnt;
    logic [FW-1:0] w_frame_cnt_nxt;
    logic          r_primed;
    logic          w_en;
    logic          w_vin;
    logic          w_s_ready;
    logic          w_frame_end;

    // Next-state, counter and combinational datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc_ctr;
        w_en        = 1'b0;
        w_vin       = 1'b0;
        w_s_ready   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_s_ready = bus.ds_ready;
                w_vin     = 1'b1;
                w_en      = bus.s_valid & bus.ds_ready;
                if (w_en && (r_cyc_ctr == LOAD_LAST)) begin
                    w_state_nxt = ST_LOOP;
                    w_cyc_nxt   = LOOP_FIRST;
                end else if (w_en) begin
                    w_cyc_nxt = r_cyc_ctr + CYC_ONE;
                end else begin
                    w_cyc_nxt = r_cyc_ctr;
                end
            end
            ST_LOOP: begin
                // Loopback never waits on the source, only on the downstream stage
                w_en = bus.ds_ready;
                if (w_en && (r_cyc_ctr == FRAME_LAST)) begin
                    w_frame_end = 1'b1;
                    w_cyc_nxt   = CYC_ZERO;
                    w_state_nxt = bus.run ? ST_LOAD : ST_IDLE;
                end else if (w_en) begin
                    w_cyc_nxt = r_cyc_ctr + CYC_ONE;
                end else begin
                    w_cyc_nxt = r_cyc_ctr;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = CYC_ZERO;
            end
        endcase
    end

    // Frame-end bookkeeping: phase rotation wraps naturally, frame count saturates
    always_comb begin
        w_phase_nxt     = r_phase;
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_frame_end) begin
            w_phase_nxt = r_phase + PHASE_INC;
            if (r_frame_cnt != FRAMES_FULL) begin
                w_frame_cnt_nxt = r_frame_cnt + FRAMES_ONE;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt;
            end
        end else begin
            w_phase_nxt     = r_phase;
            w_frame_cnt_nxt = r_frame_cnt;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cyc_ctr   <= CYC_ZERO;
            r_phase     <= CYC_ZERO;
            r_frame_cnt <= {FW{1'b0}};
            r_primed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc_ctr   <= w_cyc_nxt;
            r_phase     <= w_phase_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_primed    <= r_primed | (w_frame_cnt_nxt == FRAMES_FULL);
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.dp_en       = w_en;
    assign bus.dp_vin      = w_vin;
    assign bus.dp_din      = rst ? {WIDTH{1'b0}} : bus.s_data;
    assign bus.frame_start = w_en & (r_cyc_ctr == CYC_ZERO);
    assign bus.phase_idx   = r_phase;
    assign bus.primed      = r_primed;
    assign bus.busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_pfb_sequencer.sv
// Self-checking bench for pfb_sequencer: table vectors, directed frame corner cases and
// randomized traffic against a step-count reference model.
module tb_pfb_sequencer;
    localparam int WIDTH = 16;
    localparam int M     = 32;
    localparam int D     = 24;
    localparam int P     = 8;
    localparam int CW    = $clog2(M);

    logic clk = 1'b0;
    logic rst = 1'b1;

    pfb_sequencer_if #(.WIDTH(WIDTH), .FFT_LEN(M)) bus ();

    pfb_sequencer #(.WIDTH(WIDTH), .FFT_LEN(M), .DEC_FAC(D), .PTAPS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: total steps taken since reset and whether a frame is open
    int m_steps  = 0;
    bit m_active = 1'b0;

    logic [26:0]   obs;
    logic [4:0]    l_ctl;
    bit            l_rdy, l_en, l_fs, l_busy, l_primed;
    logic [CW-1:0] l_phase;

    assign obs = {bus.s_ready, bus.dp_en, bus.dp_vin, bus.frame_start, bus.busy,
                  bus.primed, bus.phase_idx, bus.dp_din};

    typedef struct {
        bit         run;
        bit         sv;
        bit         dr;
        logic [4:0] exp_ctl;   // {s_ready, dp_en, dp_vin, frame_start, busy}
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] model_out(input bit v, input bit dr,
                                              input logic [WIDTH-1:0] d, input bit in_rst);
        int            pos;
        int            frames;
        bit            e_rdy, e_en, e_vin, e_fs, e_primed;
        logic [CW-1:0] ph;
        pos    = m_steps % M;
        frames = m_steps / M;
        e_rdy  = 1'b0;
        e_en   = 1'b0;
        e_vin  = 1'b0;
        if (in_rst) return 27'd0;
        if (m_active && pos < D) begin
            e_rdy = dr;
            e_vin = 1'b1;
            e_en  = v & dr;
        end else if (m_active) begin
            e_en = dr;
        end
        e_fs     = e_en && (pos == 0);
        e_primed = (frames >= P);
        ph       = CW'((frames * D) % M);
        return {e_rdy, e_en, e_vin, e_fs, m_active, e_primed, ph, d};
    endfunction

    task automatic tick(input bit r, input bit v, input bit dr, input logic [WIDTH-1:0] d);
        logic [26:0] exp_v;
        @(negedge clk);
        bus.run      = r;
        bus.s_valid  = v;
        bus.ds_ready = dr;
        bus.s_data   = d;
        #1;
        exp_v = model_out(v, dr, d, rst);
        check("outputs", {37'd0, obs}, {37'd0, exp_v});
        l_ctl    = obs[26:22];
        l_rdy    = obs[26];
        l_en     = obs[25];
        l_fs     = obs[23];
        l_busy   = obs[22];
        l_primed = obs[21];
        l_phase  = obs[20:16];
        @(posedge clk);
        if (rst) begin
            m_steps  = 0;
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = r;
        end else if (exp_v[25]) begin
            m_steps++;
            if (m_steps % M == 0) m_active = r;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 1'b1, 16'h1234);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic align_frame();
        int n;
        n = 0;
        while (!(m_active && (m_steps % M == 0)) && n < 80) begin
            tick(1'b1, 1'b1, 1'b1, 16'($urandom));
            n++;
        end
        check("align_budget", 64'(n < 80), 64'd1);
    endtask

    // Run one frame with a stall window of n cycles starting when step 'at' is due
    task automatic run_frame(input int at, input int n, input bit on_ready, output int len);
        int st, stalled;
        bit started, hold;
        st = 0; stalled = 0; started = 1'b0; len = 0;
        while (st < M && len < 200) begin
            if (st == at) started = 1'b1;
            hold = started && (stalled < n);
            if (hold) stalled++;
            tick(1'b1, !(hold && !on_ready), !(hold && on_ready), 16'($urandom));
            len++;
            if (l_en) st++;
        end
    endtask

    initial begin
        int ph_q[$];
        int exp_ph [5];
        int steps, steps_at_primed, len, n;
        bit v, acc, r, dr;
        logic [WIDTH-1:0] d;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 5'b00000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 5'b00101};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 5'b11111};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'b10101};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 5'b11101};
        exp_ph = '{0, 24, 16, 8, 0};

        bus.run = 1'b0; bus.s_valid = 1'b0; bus.ds_ready = 1'b0; bus.s_data = '0;
        l_ctl = '0; l_phase = '0;

        // Table vectors from reset: idle, run sampling, load handshake cases
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(tbl[i].run, tbl[i].sv, tbl[i].dr, 16'($urandom));
            check($sformatf("table[%0d]", i), {59'd0, l_ctl}, {59'd0, tbl[i].exp_ctl});
        end

        // Continuous run: phase rotation sequence and primed after 256 steps
        do_reset();
        steps = 0; steps_at_primed = -1;
        for (int c = 0; c < 300; c++) begin
            tick(1'b1, 1'b1, 1'b1, 16'($urandom));
            if (l_fs) ph_q.push_back(int'(l_phase));
            if (l_primed && steps_at_primed < 0) steps_at_primed = steps;
            if (l_en) steps++;
        end
        check("frame_starts", 64'(ph_q.size()), 64'd10);
        for (int i = 0; i < 5; i++) begin
            if (i < ph_q.size()) check($sformatf("phase_seq[%0d]", i), 64'(ph_q[i]), 64'(exp_ph[i]));
            else check($sformatf("phase_seq[%0d]", i), 64'hFFFF, 64'(exp_ph[i]));
        end
        check("primed_steps", 64'(steps_at_primed), 64'd256);

        // Starvation in LOAD stretches the frame; in LOOP it does not; back-pressure in LOOP does
        align_frame();
        run_frame(10, 5, 1'b0, len);
        check("starve_load_len", 64'(len), 64'd37);
        run_frame(26, 5, 1'b0, len);
        check("starve_loop_len", 64'(len), 64'd32);
        run_frame(28, 3, 1'b1, len);
        check("bp_loop_len", 64'(len), 64'd35);

        // run dropped at cyc_ctr=5: frame completes, then idle holding phase
        do_reset();
        tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        steps = 0; n = 0;
        do begin
            tick(1'b0, 1'b1, 1'b1, 16'($urandom));
            if (l_en) steps++;
            n++;
        end while (l_busy && n < 100);
        check("run_drop_steps", 64'(steps), 64'd27);
        check("run_drop_phase", 64'(l_phase), 64'd24);
        tick(1'b0, 1'b1, 1'b1, 16'($urandom));
        tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        check("resume_fs", 64'(l_fs), 64'd1);
        check("resume_phase", 64'(l_phase), 64'd24);

        // Randomized traffic; source holds s_valid until accepted
        v = 1'b0; acc = 1'b1; d = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(9) != 0);
            dr = ($urandom_range(3) != 0);
            if (!v || acc) begin
                v = 1'($urandom_range(1));
                d = 16'($urandom);
            end
            tick(r, v, dr, d);
            acc = l_rdy && v;
        end

        // Asynchronous reset between edges while in LOOP
        n = 0;
        while (!(m_active && (m_steps % M) >= D) && n < 100) begin
            tick(1'b1, 1'b1, 1'b1, 16'($urandom));
            n++;
        end
        check("loop_reach", 64'(n < 100), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.run = 1'b0;
        #1;
        check("async_rst_outputs", {37'd0, obs}, 64'd0);
        m_steps = 0;
        m_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        tick(1'b1, 1'b1, 1'b1, 16'($urandom));
        check("restart_fs", 64'(l_fs), 64'd1);
        check("restart_phase", 64'(l_phase), 64'd0);
        check("restart_primed", 64'(l_primed), 64'd0);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 1'b1, 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
